// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data bus logic.
// Holds the access-size encodings, the FSM state type, the byte-enable width,
// and helper functions for alignment checks, byte enables and store-lane
// replication. Imported by data_mem_stage and load_extend.
package mem_pkg;

  localparam int BE_WIDTH = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Size 2'b11 falls into the default arm everywhere and behaves as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [BE_WIDTH-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return BE_WIDTH'(1) << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the low byte/half across all lanes so the memory can pick the
  // enabled lane without a shifter on the store path.
  function automatic logic [31:0] store_repl(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data lane select and extension.
// Ports:
//   rdata_i    read word from the data bus
//   off_i      byte offset addr[1:0] of the access
//   size_i     access size (byte/half/word, 11 = word)
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o     extended load result
module load_extend
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] lane;

  always_comb begin
    lane = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{(WIDTH-8){~unsigned_i & lane[7]}}, lane[7:0]};
      SZ_HALF: data_o = {{(WIDTH-16){~unsigned_i & lane[15]}}, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM stage of the 5-stage RISC-V pipeline.
// Drives a single-port req/ready data bus, builds byte enables and
// lane-replicated store data, stalls the pipeline while an access is
// outstanding and returns extended load data to the MEM/WB register.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mem_read_in/mem_write_in    load/store in MEM (write wins if both)
//   size_in, unsigned_in        access size, zero-extend select
//   addr_in, wdata_in           byte address, store data
//   dbus_req/we/addr/be/wdata   registered bus request outputs
//   dbus_ready, dbus_rdata      bus completion and read data
//   load_data                   extended load result (valid in DONE)
//   stall                       pipeline freeze
//   misalign_err, bus_err       one-cycle error flags
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// ACCESS cycles without dbus_ready (bus_err pulses); otherwise bus_err is 0.
module data_mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [1:0]          size_in,
  input  logic                unsigned_in,
  input  logic [WIDTH-1:0]    addr_in,
  input  logic [WIDTH-1:0]    wdata_in,
  output logic                dbus_req,
  output logic                dbus_we,
  output logic [WIDTH-1:0]    dbus_addr,
  output logic [BE_WIDTH-1:0] dbus_be,
  output logic [WIDTH-1:0]    dbus_wdata,
  input  logic                dbus_ready,
  input  logic [WIDTH-1:0]    dbus_rdata,
  output logic [WIDTH-1:0]    load_data,
  output logic                stall,
  output logic                misalign_err,
  output logic                bus_err
);

  if (WIDTH != 32) begin : g_bad_width
    $error("data_mem_stage supports WIDTH=32 only");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("data_mem_stage requires TIMEOUT >= 1");
  end

  mem_state_t          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [BE_WIDTH-1:0] be_q, be_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [WIDTH-1:0]    ld_q, ld_d;
  logic                berr_q, berr_d;

  logic                access;
  logic                aligned;
  logic [WIDTH-1:0]    ext_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Extension uses the offset/size latched at request time, not the live
  // inputs, since the EX/MEM register is frozen but not trusted here.
  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .rdata_i    (dbus_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign access  = mem_read_in | mem_write_in;
  assign aligned = is_aligned(size_in, addr_in[1:0]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    ld_d    = ld_q;
    berr_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mem_write_in;
          addr_d  = {addr_in[WIDTH-1:2], 2'b00};
          be_d    = byte_en(size_in, addr_in[1:0]);
          wdata_d = store_repl(size_in, wdata_in);
          off_d   = addr_in[1:0];
          size_d  = size_in;
          uns_d   = unsigned_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (dbus_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = ext_data;
        end
`ifdef MEM_TIMEOUT_EN
        // Ready on the limit cycle takes the branch above.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = '0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      ld_q    <= '0;
      berr_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      ld_q    <= ld_d;
      berr_q  <= berr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = (state_q == DONE) ? ld_q : '0;

  // rst gates the combinational flags so they fall with the reset edge even
  // while the frozen instruction is still present at the inputs.
  assign stall        = ~rst & (((state_q == IDLE) & access & aligned) | (state_q == ACCESS));
  assign misalign_err = ~rst & (state_q == IDLE) & access & ~aligned;

`ifdef MEM_TIMEOUT_EN
  assign bus_err = berr_q;
`else
  assign bus_err = 1'b0;
  logic unused_berr;
  assign unused_berr = berr_q;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, unsigned_in;
  logic [1:0]  size_in;
  logic [31:0] addr_in, wdata_in;
  logic        dbus_req, dbus_we, dbus_ready;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, load_data;
  logic [3:0]  dbus_be;
  logic        stall, misalign_err, bus_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] load;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_stage #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .size_in      (size_in),
    .unsigned_in  (unsigned_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ready   (dbus_ready),
    .dbus_rdata   (dbus_rdata),
    .load_data    (load_data),
    .stall        (stall),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one aligned access and walks it through IDLE -> ACCESS x (waits+1) -> DONE.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits,
                           input logic [3:0] e_be, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [31:0] e_load);
    exp_t e;
    int   stalls;
    int   reqs;
    logic prev_req;
    e.be = e_be; e.addr = e_addr; e.wdata = e_wdata; e.we = wr; e.load = e_load;
    sb_q.push_back(e);
    mem_read_in = rd; mem_write_in = wr; size_in = sz; unsigned_in = uns;
    addr_in = addr; wdata_in = wdata; dbus_ready = 1'b0;
    #1;
    check({tag, ".idle_stall"}, 32'(stall), 32'd1);
    check({tag, ".idle_req"}, 32'(dbus_req), 32'd0);
    stalls = 1; reqs = 0; prev_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (dbus_req && !prev_req) reqs++;
      prev_req = dbus_req;
      if (stall) stalls++;
      check($sformatf("%s.be[%0d]", tag, i), 32'(dbus_be), 32'(sb_q[0].be));
      check($sformatf("%s.addr[%0d]", tag, i), dbus_addr, sb_q[0].addr);
      check($sformatf("%s.we[%0d]", tag, i), 32'(dbus_we), 32'(sb_q[0].we));
      if (wr) check($sformatf("%s.wdata[%0d]", tag, i), dbus_wdata, sb_q[0].wdata);
      if (i == waits) begin
        dbus_ready = 1'b1; dbus_rdata = rdata;
      end else begin
        dbus_ready = 1'b0; dbus_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    dbus_ready = 1'b0; dbus_rdata = $urandom;
    // DONE cycle, instruction still held at the inputs
    e = sb_q.pop_front();
    check({tag, ".load_data"}, load_data, e.load);
    check({tag, ".done_stall"}, 32'(stall), 32'd0);
    check({tag, ".done_req"}, 32'(dbus_req), 32'd0);
    check({tag, ".bus_err"}, 32'(bus_err), 32'd0);
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(waits + 2));
    check({tag, ".req_issues"}, 32'(reqs), 32'd1);
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(posedge clk); #1;
    check({tag, ".after_load_data"}, load_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; size_in = 2'b00;
    unsigned_in = 1'b0; addr_in = '0; wdata_in = '0; dbus_ready = 1'b0; dbus_rdata = '0;
    #12;
    check("rst.req", 32'(dbus_req), 32'd0);
    check("rst.we", 32'(dbus_we), 32'd0);
    check("rst.addr", dbus_addr, 32'd0);
    check("rst.be", 32'(dbus_be), 32'd0);
    check("rst.wdata", dbus_wdata, 32'd0);
    check("rst.load", load_data, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.misalign", 32'(misalign_err), 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access("sw104", 1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 0,
              4'b1111, 32'h104, 32'hDEADBEEF, 32'h0);
    do_access("sb103", 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0,
              4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0);
    do_access("lb103", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 0,
              4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
    do_access("lbu103", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 0,
              4'b1000, 32'h100, 32'h0, 32'h00000080);
    do_access("lh102", 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234, 3,
              4'b1100, 32'h100, 32'h0, 32'hFFFF8001);
    do_access("lhu102", 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80011234, 1,
              4'b1100, 32'h100, 32'h0, 32'h00008001);
    do_access("lb101", 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00007F00, 0,
              4'b0010, 32'h100, 32'h0, 32'h0000007F);
    do_access("sh106", 1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234BEEF, 32'h0, 2,
              4'b1100, 32'h104, 32'hBEEFBEEF, 32'h0);
    do_access("rdwr108", 1'b1, 1'b1, 2'b10, 1'b0, 32'h108, 32'h12345678, 32'h0, 0,
              4'b1111, 32'h108, 32'h12345678, 32'h0);
    do_access("lw10c", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'hCAFEF00D, 2,
              4'b1111, 32'h10C, 32'h0, 32'hCAFEF00D);
    do_access("sz11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h110, 32'h0, 32'h8000F00D, 0,
              4'b1111, 32'h110, 32'h0, 32'h8000F00D);

    // misaligned word load
    mem_read_in = 1'b1; size_in = 2'b10; unsigned_in = 1'b0; addr_in = 32'h101;
    #1;
    check("mis_lw.err", 32'(misalign_err), 32'd1);
    check("mis_lw.req", 32'(dbus_req), 32'd0);
    check("mis_lw.stall", 32'(stall), 32'd0);
    check("mis_lw.load", load_data, 32'd0);
    mem_read_in = 1'b0;
    @(posedge clk); #1;
    check("mis_lw.req_next", 32'(dbus_req), 32'd0);
    check("mis_lw.err_next", 32'(misalign_err), 32'd0);

    // misaligned half store is suppressed
    mem_write_in = 1'b1; size_in = 2'b01; addr_in = 32'h103; wdata_in = 32'h5555;
    #1;
    check("mis_sh.err", 32'(misalign_err), 32'd1);
    check("mis_sh.stall", 32'(stall), 32'd0);
    mem_write_in = 1'b0;
    @(posedge clk); #1;
    check("mis_sh.req_next", 32'(dbus_req), 32'd0);
    check("mis_sh.we_next", 32'(dbus_we), 32'd0);

    // dbus_ready outside ACCESS is ignored
    dbus_ready = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("late_rdy.req", 32'(dbus_req), 32'd0);
    check("late_rdy.load", load_data, 32'd0);
    check("late_rdy.stall", 32'(stall), 32'd0);
    dbus_ready = 1'b0;

    // reset during the second ACCESS cycle
    mem_read_in = 1'b1; size_in = 2'b10; addr_in = 32'h200;
    @(posedge clk); #1;
    check("rstmid.req_a1", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    check("rstmid.stall_a2", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid.req", 32'(dbus_req), 32'd0);
    check("rstmid.stall", 32'(stall), 32'd0);
    check("rstmid.load", load_data, 32'd0);
    check("rstmid.addr", dbus_addr, 32'd0);
    mem_read_in = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid.req_after", 32'(dbus_req), 32'd0);
    do_access("post_rst", 1'b1, 1'b0, 2'b01, 1'b0, 32'h204, 32'h0, 32'h00007FFF, 1,
              4'b0011, 32'h204, 32'h0, 32'h00007FFF);

`ifdef MEM_TIMEOUT_EN
    mem_read_in = 1'b1; size_in = 2'b10; addr_in = 32'h300; dbus_ready = 1'b0;
    @(posedge clk); #1;
    mem_read_in = 1'b0;
    cyc = 1;
    while (!bus_err && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("tmo.cycle", 32'(cyc), 32'd17);
    check("tmo.bus_err", 32'(bus_err), 32'd1);
    check("tmo.load", load_data, 32'd0);
    check("tmo.stall", 32'(stall), 32'd0);
    check("tmo.req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;
    check("tmo.bus_err_next", 32'(bus_err), 32'd0);
`else
    cyc = 0;
    check("no_tmo.bus_err", 32'(bus_err), 32'(cyc));
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
